// File: rtl/uart_tx_fifo.sv
// Byte-buffered UART transmitter (8N1/8N2, LSB first) paced by an external 1x baud tick.
// Latency: a byte pushed into an empty FIFO while idle starts its start bit on the first tick edge after the push.
// Backpressure: tx_ready drops while the FIFO is full; pushes are ignored then, even when a pop happens that edge.

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    output logic          push_rdy,
    input  logic          pop_en,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Readiness comes from the registered count only, so a same-edge pop never opens a full FIFO.
    assign push_rdy = (count != CW'(DEPTH));
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_en && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_nxt;
    logic                 stop_cnt_q, stop_cnt_nxt;
    logic                 tx_q, tx_nxt;
    logic                 busy_q, busy_nxt;
    logic                 pop_en;
    logic [DATA_BITS-1:0] head_dat;

    sync_fifo #(
        .W     (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (tx_valid),
        .push_dat (tx_data),
        .push_rdy (tx_ready),
        .pop_en   (pop_en),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign tx   = tx_q;
    assign busy = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            shift_q    <= shift_nxt;
            bit_cnt_q  <= bit_cnt_nxt;
            stop_cnt_q <= stop_cnt_nxt;
            tx_q       <= tx_nxt;
            busy_q     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt_q;
        stop_cnt_nxt = stop_cnt_q;
        tx_nxt       = tx_q;
        busy_nxt     = busy_q;
        pop_en       = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (fifo_count != '0) begin
                        pop_en    = 1'b1;
                        shift_nxt = head_dat;
                        tx_nxt    = 1'b0;
                        busy_nxt  = 1'b1;
                        state_nxt = START;
                    end
                end
                START: begin
                    tx_nxt      = shift_q[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_nxt       = 1'b1;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = STOP;
                    end else begin
                        shift_nxt   = shift_q >> 1;
                        tx_nxt      = shift_q[1];
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_cnt_q == STOP_LAST) begin
                        // Queued byte goes straight into its start bit, no idle gap.
                        if (fifo_count != '0) begin
                            pop_en    = 1'b1;
                            shift_nxt = head_dat;
                            tx_nxt    = 1'b0;
                            state_nxt = START;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven frame vectors plus directed multi-cycle sequences.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_valid2;
    logic       tx_ready, tx, busy;
    logic [2:0] fifo_count;
    logic       tx_ready2, tx2, busy2;
    logic [2:0] fifo_count2;

    logic       tick_en;
    logic       one_tick;
    logic [1:0] phase;
    logic       last_tx;
    int         rx_st;
    logic [7:0] rx_sh;
    logic [7:0] rx_q [$];
    int         rx_err;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] d;
        logic [0:9] bits;
    } frame_vec_t;
    frame_vec_t vecs [4];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .fifo_count(fifo_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Baud tick source and a line receiver for dut, in one process so sampling never races driving.
    initial begin
        baud_tick = 1'b0;
        phase     = 2'd0;
        last_tx   = 1'b1;
        rx_st     = 0;
        rx_sh     = 8'h00;
        rx_err    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_st = 0;
            end else if (baud_tick) begin
                if (rx_st == 0) begin
                    if (last_tx == 1'b0) rx_st = 1;
                end else if (rx_st <= 8) begin
                    rx_sh = {last_tx, rx_sh[7:1]};
                    rx_st++;
                end else begin
                    if (last_tx == 1'b1) rx_q.push_back(rx_sh);
                    else rx_err++;
                    rx_st = 0;
                end
            end
            last_tx = tx;
            if (tick_en) begin
                baud_tick = (phase == 2'd3);
                phase     = phase + 2'd1;
            end else if (one_tick) begin
                baud_tick = 1'b1;
                one_tick  = 1'b0;
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    task automatic push1(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Waits for the start bit, then checks n line levels of 4 clks each with busy held, then idle.
    task automatic run_levels(input string name, input logic [0:19] exp, input int n);
        int w = 0;
        while (tx !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) begin
            chk({name, "_start_seen"}, 32'(tx), 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s_bit%0d_early", name, i), 32'(tx), 32'(exp[i]));
                chk($sformatf("%s_busy%0d", name, i), 32'(busy), 1);
                repeat (3) @(negedge clk);
                chk($sformatf("%s_bit%0d_late", name, i), 32'(tx), 32'(exp[i]));
                chk($sformatf("%s_busy%0d_late", name, i), 32'(busy), 1);
                @(negedge clk);
            end
            chk({name, "_idle_tx"}, 32'(tx), 1);
            chk({name, "_idle_busy"}, 32'(busy), 0);
        end
    endtask

    initial begin
        int low_cnt, busy_cnt, w;
        vecs[0] = '{8'h55, 10'b0101010101};
        vecs[1] = '{8'h01, 10'b0100000000 | 10'b0000000001};
        vecs[2] = '{8'h80, 10'b0000000011};
        vecs[3] = '{8'hA3, 10'b0110001011};

        rst = 1'b1; tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = 8'h00;
        tick_en = 1'b1; one_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_tx2", 32'(tx2), 1);
        chk("rst_ready2", 32'(tx_ready2), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames from the vector table.
        for (int i = 0; i < 4; i++) begin
            push1(vecs[i].d);
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 1);
            run_levels($sformatf("vec%0d", i), {vecs[i].bits, 10'h000}, 10);
            repeat (8) @(negedge clk);
        end

        // Back-to-back frames: stop of 0xA3 runs straight into start of 0x0F.
        tick_en = 1'b0;
        @(negedge clk);
        push1(8'hA3);
        push1(8'h0F);
        chk("b2b_count", 32'(fifo_count), 2);
        tick_en = 1'b1;
        run_levels("b2b", 20'b0110001011_0111100001, 20);
        repeat (8) @(negedge clk);

        // Two stop bits: 0xFF is low for one tick and high for ten, busy for eleven.
        tx_data = 8'hFF; tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        low_cnt = 0; busy_cnt = 0;
        repeat (60) begin
            if (tx2 === 1'b0) low_cnt++;
            if (busy2 === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        chk("stop2_low_clks", 32'(low_cnt), 4);
        chk("stop2_busy_clks", 32'(busy_cnt), 44);
        chk("stop2_end_tx", 32'(tx2), 1);

        // Reset during data bit 3 of 0x3C with two words still queued.
        tick_en = 1'b0;
        @(negedge clk);
        push1(8'h3C); push1(8'h11); push1(8'h22);
        chk("rstmid_count3", 32'(fifo_count), 3);
        tick_en = 1'b1;
        w = 0;
        while (tx !== 1'b0 && w < 40) begin @(negedge clk); w++; end
        chk("rstmid_start_seen", 32'(tx), 0);
        repeat (17) @(negedge clk);
        chk("rstmid_bit3", 32'(tx), 1);
        chk("rstmid_busy_before", 32'(busy), 1);
        chk("rstmid_count_before", 32'(fifo_count), 2);
        rst = 1'b1;
        #1;
        chk("rstmid_tx", 32'(tx), 1);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_count", 32'(fifo_count), 0);
        chk("rstmid_ready", 32'(tx_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        low_cnt = 0; busy_cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (tx === 1'b0) low_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        chk("post_rst_low_clks", 32'(low_cnt), 0);
        chk("post_rst_busy_clks", 32'(busy_cnt), 0);
        chk("post_rst_rx", 32'(rx_q.size()), 0);

        // Fill with ticks stopped, then pop on the same edge as a push attempt to a full FIFO.
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_ready%0d", i), 32'(tx_ready), (i < 4) ? 1 : 0);
            push1(8'hD1 + 8'(i));
        end
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(tx_ready), 0);
        chk("full_tx", 32'(tx), 1);
        @(posedge clk);
        one_tick = 1'b1;
        @(negedge clk);
        tx_data = 8'h99; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("fullpop_count", 32'(fifo_count), 3);
        chk("fullpop_ready", 32'(tx_ready), 1);
        chk("fullpop_tx", 32'(tx), 0);
        chk("fullpop_busy", 32'(busy), 1);
        tick_en = 1'b1;
        w = 0;
        while (rx_q.size() < 4 && w < 600) begin @(negedge clk); w++; end
        repeat (60) @(negedge clk);
        chk("order_rx_count", 32'(rx_q.size()), 4);
        chk("order_rx_err", 32'(rx_err), 0);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) chk($sformatf("order_byte%0d", i), 32'(rx_q[i]), 32'(8'hD1 + 8'(i)));
        end
        chk("final_busy", 32'(busy), 0);
        chk("final_count", 32'(fifo_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
